// File: rtl/branch_ctrl_pkg.sv
// Shared encodings for the ID-stage branch resolution controller:
// opcodes, PC-select codes, FSM states and a saturating counter helper.
package branch_ctrl_pkg;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_STALL   = 2'b01,
        ST_RESOLVE = 2'b10
    } state_e;

    // Holds at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/br_hazard_detect.sv
// Computes how many cycles a beq in ID must wait for its source operands;
// an EX-stage producer takes priority over a MEM-stage load.
module br_hazard_detect
    import branch_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_regwrite,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic       mem_memread,
    input  logic [4:0] mem_rd,
    output logic [1:0] stall_cnt
);

    logic ex_match;
    logic mem_match;

    // Register 0 is hardwired to zero, so it never creates a dependency.
    assign ex_match  = (ex_rd  != 5'd0) && ((ex_rd  == id_rs) || (ex_rd  == id_rt));
    assign mem_match = (mem_rd != 5'd0) && ((mem_rd == id_rs) || (mem_rd == id_rt));

    always_comb begin
        stall_cnt = 2'd0;
        if (ex_regwrite && ex_match) begin
            stall_cnt = ex_memread ? 2'd2 : 2'd1;
        end else if (mem_memread && mem_match) begin
            stall_cnt = 2'd1;
        end
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch/jump controller: stalls beq until its operands are ready,
// then redirects the PC and counts resolved and taken branches.
module branch_resolve_ctrl
    import branch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_regwrite,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        mem_memread,
    input  logic [4:0]  mem_rd,
    input  logic        cmp_eq,
    output logic        stall,
    output logic        bubble,
    output logic        if_flush,
    output logic [1:0]  pc_sel,
    output logic [15:0] br_total,
    output logic [15:0] br_taken
);

    state_e      state_q, state_d;
    logic [1:0]  scnt_q, scnt_d;
    logic [15:0] total_q, total_d;
    logic [15:0] taken_q, taken_d;
    logic [1:0]  hz_cnt;
    logic        do_resolve;

    br_hazard_detect u_hazard (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_regwrite (ex_regwrite),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .mem_memread (mem_memread),
        .mem_rd      (mem_rd),
        .stall_cnt   (hz_cnt)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d    = state_q;
        scnt_d     = scnt_q;
        total_d    = total_q;
        taken_d    = taken_q;
        stall      = 1'b0;
        bubble     = 1'b0;
        if_flush   = 1'b0;
        pc_sel     = PC_SEQ;
        do_resolve = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (id_valid && id_opcode == OP_J) begin
                    pc_sel   = PC_JMP;
                    if_flush = 1'b1;
                end else if (id_valid && id_opcode == OP_BEQ) begin
                    if (hz_cnt != 2'd0) begin
                        stall   = 1'b1;
                        bubble  = 1'b1;
                        scnt_d  = hz_cnt - 2'd1;
                        state_d = (hz_cnt == 2'd2) ? ST_STALL : ST_RESOLVE;
                    end else begin
                        do_resolve = 1'b1;
                    end
                end
            end
            ST_STALL: begin
                stall   = 1'b1;
                bubble  = 1'b1;
                scnt_d  = scnt_q - 2'd1;
                state_d = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                // ID is held here, so the instruction is the stalled beq.
                do_resolve = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase

        if (do_resolve) begin
            total_d = sat_inc(total_q);
            scnt_d  = 2'd0;
            state_d = ST_RUN;
            if (cmp_eq) begin
                pc_sel   = PC_BR;
                if_flush = 1'b1;
                taken_d  = sat_inc(taken_q);
            end
        end

        // Control outputs must read zero the moment reset asserts, not only after the state clears.
        if (!rst_n) begin
            stall    = 1'b0;
            bubble   = 1'b0;
            if_flush = 1'b0;
            pc_sel   = PC_SEQ;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            scnt_q  <= 2'd0;
            total_q <= 16'd0;
            taken_q <= 16'd0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            total_q <= total_d;
            taken_q <= taken_d;
        end
    end

    assign br_total = total_q;
    assign br_taken = taken_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: directed cycles push expected
// outputs, which are popped and compared at the falling edge.
module tb_branch_resolve_ctrl;
    import branch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs, id_rt;
    logic        ex_regwrite, ex_memread;
    logic [4:0]  ex_rd;
    logic        mem_memread;
    logic [4:0]  mem_rd;
    logic        cmp_eq;
    logic        stall, bubble, if_flush;
    logic [1:0]  pc_sel;
    logic [15:0] br_total, br_taken;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic        stall;
        logic        bubble;
        logic        flush;
        logic [1:0]  pc;
        logic [15:0] total;
        logic [15:0] taken;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_total = 16'd0;
    logic [15:0] exp_taken = 16'd0;

    always #5 clk = ~clk;

    branch_resolve_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_opcode   (id_opcode),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_regwrite (ex_regwrite),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .mem_memread (mem_memread),
        .mem_rd      (mem_rd),
        .cmp_eq      (cmp_eq),
        .stall       (stall),
        .bubble      (bubble),
        .if_flush    (if_flush),
        .pc_sel      (pc_sel),
        .br_total    (br_total),
        .br_taken    (br_taken)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic exw, input logic exm, input logic [4:0] exrd,
                         input logic mm, input logic [4:0] mrd, input logic eq);
        id_valid    = v;
        id_opcode   = op;
        id_rs       = rs;
        id_rt       = rt;
        ex_regwrite = exw;
        ex_memread  = exm;
        ex_rd       = exrd;
        mem_memread = mm;
        mem_rd      = mrd;
        cmp_eq      = eq;
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, "_stall"},  32'(stall),    32'(e.stall));
        check({e.tag, "_bubble"}, 32'(bubble),   32'(e.bubble));
        check({e.tag, "_flush"},  32'(if_flush), 32'(e.flush));
        check({e.tag, "_pc_sel"}, 32'(pc_sel),   32'(e.pc));
        check({e.tag, "_total"},  32'(br_total), 32'(e.total));
        check({e.tag, "_taken"},  32'(br_taken), 32'(e.taken));
    endtask

    // One clock cycle: called just after a rising edge; drives, checks at the
    // falling edge, then advances past the next rising edge and updates the model.
    task automatic step(input string tag, input logic v, input logic [5:0] op,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic exw, input logic exm, input logic [4:0] exrd,
                        input logic mm, input logic [4:0] mrd, input logic eq,
                        input logic e_st, input logic e_bb, input logic e_fl, input logic [1:0] e_pc,
                        input logic res);
        drive(v, op, rs, rt, exw, exm, exrd, mm, mrd, eq);
        sb.push_back('{tag, e_st, e_bb, e_fl, e_pc, exp_total, exp_taken});
        @(negedge clk);
        compare_head();
        @(posedge clk);
        #1;
        if (res) begin
            exp_total = model_inc(exp_total);
            if (eq) exp_taken = model_inc(exp_taken);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #12;
        sb.push_back('{"reset", 1'b0, 1'b0, 1'b0, PC_SEQ, 16'd0, 16'd0});
        compare_head();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle and non-branch opcodes leave every control output low.
        step("idle",  1'b0, OP_BEQ,    5'd3, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 0, 0, 0, PC_SEQ, 0);
        step("other", 1'b1, 6'b100011, 5'd3, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 0, 0, 0, PC_SEQ, 0);

        // beq without hazards resolves taken in the same cycle.
        step("beq_nohz", 1'b1, OP_BEQ, 5'd3, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 0, 0, 1, PC_BR, 1);

        // EX-load on rs: two stall cycles, resolves not-taken in the third.
        step("exld_c1", 1'b1, OP_BEQ, 5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1, 1, 0, PC_SEQ, 0);
        step("exld_c2", 1'b1, OP_BEQ, 5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1, 1, 0, PC_SEQ, 0);
        step("exld_c3", 1'b1, OP_BEQ, 5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 0, 0, 0, PC_SEQ, 1);

        // EX-ALU and MEM-load on rt together: EX wins, one stall cycle.
        step("exalu_c1", 1'b1, OP_BEQ, 5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1, 1, 0, PC_SEQ, 0);
        step("exalu_c2", 1'b1, OP_BEQ, 5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 0, 0, 1, PC_BR, 1);

        // MEM-load alone: one stall cycle.
        step("memld_c1", 1'b1, OP_BEQ, 5'd9, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b1, 1, 1, 0, PC_SEQ, 0);
        step("memld_c2", 1'b1, OP_BEQ, 5'd9, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b1, 0, 0, 1, PC_BR, 1);

        // Destination register 0 never causes a stall, even when rs is 0.
        step("rd_zero", 1'b1, OP_BEQ, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 0, 0, 0, PC_SEQ, 1);

        // Jump ignores hazards and never counts.
        step("jump", 1'b1, OP_J, 5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 0, 0, 1, PC_JMP, 0);
        step("after_j", 1'b0, OP_J, 5'd5, 5'd6, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 0, 0, 0, PC_SEQ, 0);

        // Reset asserted during a STALL cycle clears everything at once.
        step("rst_c1", 1'b1, OP_BEQ, 5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 1, 1, 0, PC_SEQ, 0);
        #2 rst_n = 1'b0;
        #1;
        exp_total = 16'd0;
        exp_taken = 16'd0;
        sb.push_back('{"rst_mid", 1'b0, 1'b0, 1'b0, PC_SEQ, 16'd0, 16'd0});
        compare_head();
        drive(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("post_rst_idle", 1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 0, 0, 0, PC_SEQ, 0);
        step("post_rst_beq",  1'b1, OP_BEQ, 5'd3, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 0, 0, 1, PC_BR, 1);
        step("post_rst_cnt",  1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 0, 0, 0, PC_SEQ, 0);

        // Saturation: run taken beqs up to FFFE, then two more resolves.
        drive(1'b1, OP_BEQ, 5'd3, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        while (exp_total != 16'hFFFE) begin
            @(posedge clk);
            exp_total = model_inc(exp_total);
            exp_taken = model_inc(exp_taken);
        end
        #1;
        step("sat_fffe", 1'b1, OP_BEQ, 5'd3, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 0, 0, 1, PC_BR, 1);
        step("sat_ffff", 1'b1, OP_BEQ, 5'd3, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 0, 0, 1, PC_BR, 1);
        step("sat_hold", 1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 0, 0, 0, PC_SEQ, 0);
        check("sat_model_total", 32'(br_total), 32'h0000FFFF);
        check("sat_model_taken", 32'(br_taken), 32'h0000FFFF);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
